mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported main memory between the MIPS core's instruction-fetch port and data port. The core issues level-held requests on each port. The arbiter picks one and drives a registered command to memory with a fixed access latency, then returns read data with a one-cycle acknowledge. It sits between the core's PC/Instr and memAddress/memWriteData/memReadData buses and a unified memory, and supplies the stall information the core needs for multicycle memory.

## Interface
Parameters:
- MEM_LAT, 2: cycles from memEn to valid memRdata; legal range 1..15.
- AW, 32: address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- iReq  in  1  instruction read request; held until iAck.
- iAddr  in  AW  instruction address; stable while iReq is high.
- iAck  out  1  one-cycle completion pulse.
- iRdata  out  32  fetched word; valid when iAck=1.
- dReq  in  1  data request; held until dAck.
- dWe  in  1  1 = write, 0 = read; stable while dReq is high.
- dAddr  in  AW  data address.
- dWdata  in  32  write data.
- dAck  out  1  one-cycle completion pulse.
- dRdata  out  32  read data; valid when dAck=1 and the access was a read.
- memEn  out  1  one-cycle command strobe.
- memWe  out  1  write enable; asserted together with memEn.
- memAddr  out  AW  registered address; held for the whole access.
- memWdata  out  32  registered write data; held for the whole access.
- memRdata  in  32  memory read data.
- busy  out  1  high in ACCESS and DONE.

## Operation
- The FSM has three states: IDLE, ACCESS, DONE. A 4-bit latency counter cnt and a lastGrant register (I or D) support it.
- In IDLE, the arbiter samples the eligible requests at each edge.
  - Only one request eligible: grant it.
  - Both eligible: grant the port other than lastGrant (round-robin).
  - On a grant, register addr, we (0 for I) and wdata into the mem* outputs, set owner and lastGrant, set cnt=1, and go to ACCESS.
- In ACCESS:
  - memEn=1 only while cnt==1; memWe=owner-is-D and dWe.
  - cnt increments each cycle.
  - At the edge where cnt==MEM_LAT: capture memRdata into the owner's Rdata register (reads only) and go to DONE.
- In DONE, the owner's Ack is 1 for exactly this cycle.
  - The acked port is ineligible during DONE, because its req still refers to the finished transfer.
  - If the other port's req is high, grant it at the end of DONE, which goes directly to ACCESS (back-to-back). Otherwise go to IDLE.
- Writes: dAck is still returned after MEM_LAT. dRdata is not updated and keeps its previous value.
- iRdata and dRdata hold their values between acks.
- memAddr and memWdata hold the last command after the access; memEn and memWe are 0 outside the strobe.

## Timing
- Reset (synchronous, any state): state=IDLE, cnt=0, lastGrant=I (data wins the first tie).
  - iAck, dAck, memEn, memWe and busy are 0.
  - memAddr, memWdata, iRdata and dRdata are 0.
  - An in-flight access is dropped with no ack.
- Request sampled at edge E0:
  - memEn=1 in cycle 1.
  - memRdata is sampled at the end of cycle MEM_LAT.
  - Ack is high in cycle MEM_LAT+1.
- Throughput:
  - Alternating ports: one access per MEM_LAT+1 cycles.
  - The same port twice: MEM_LAT+2 cycles, because it must pass through IDLE.
- MEM_LAT=1: ACCESS lasts one cycle, with memEn and the capture in the same cycle.
- A req dropped before its ack while in ACCESS is ignored: the access completes and the ack is still pulsed.

## Configuration
- ARB_FIXED_PRIO_EN defined: every tie, in IDLE, is granted to D; lastGrant is unused.
- ARB_FIXED_PRIO_EN undefined (default): round-robin on ties as described above.
- DONE behaviour is identical in both builds.

## Test plan
- I read, MEM_LAT=2:
  - Stimulus: iReq, iAddr=0x40 at E0; memory returns 0x8C220004.
  - Required: memEn in cycle 1 with memAddr=0x40 and memWe=0; iAck=1 and iRdata=0x8C220004 in cycle 3; busy in cycles 1–3.
- D write:
  - Stimulus: dWe=1, dAddr=0x100, dWdata=0xDEADBEEF.
  - Required: memWe and memEn in cycle 1; memAddr and memWdata stable through dAck in cycle 3; dRdata unchanged.
- Tie after reset, both reqs rise together:
  - Required: D is served first; I gets memEn in the cycle after dAck; iAck follows MEM_LAT+1 cycles after dAck.
- Repeated ties, two separate idle-to-tie events:
  - Default build: the grant order is D then I.
  - With ARB_FIXED_PRIO_EN: D then D.
- Continuous: both reqs held for four accesses.
  - Required: acks alternate D, I, D, I with no IDLE cycles between them.
- RESET asserted in cycle 1 of an I read:
  - Required: no iAck; all outputs 0 the next cycle; a later dReq is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's instruction-fetch and data ports onto one single-ported memory with fixed latency.
// Ties in IDLE are round-robin; defining ARB_FIXED_PRIO_EN always grants ties to the data port.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          iReq,
  input  logic [AW-1:0] iAddr,
  output logic          iAck,
  output logic [31:0]   iRdata,
  input  logic          dReq,
  input  logic          dWe,
  input  logic [AW-1:0] dAddr,
  input  logic [31:0]   dWdata,
  output logic          dAck,
  output logic [31:0]   dRdata,
  output logic          memEn,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [31:0]   memWdata,
  input  logic [31:0]   memRdata,
  output logic          busy
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       owner_d_reg;
  logic       we_reg;
`ifndef ARB_FIXED_PRIO_EN
  logic       last_d_reg;
`endif
  logic       grant_i;
  logic       grant_d;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_reg)
      IDLE: begin
        if (iReq && dReq) begin
`ifdef ARB_FIXED_PRIO_EN
          grant_d = 1'b1;
`else
          grant_d = !last_d_reg;
          grant_i = last_d_reg;
`endif
        end else begin
          grant_i = iReq;
          grant_d = dReq;
        end
      end
      DONE: begin
        // The port being acked still holds req for the finished transfer, so only the other may win.
        grant_i = owner_d_reg && iReq;
        grant_d = !owner_d_reg && dReq;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      owner_d_reg <= 1'b0;
      we_reg      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_d_reg  <= 1'b0;
`endif
      iAck        <= 1'b0;
      dAck        <= 1'b0;
      iRdata      <= '0;
      dRdata      <= '0;
      memEn       <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWdata    <= '0;
      busy        <= 1'b0;
    end else begin
      memEn <= 1'b0;
      memWe <= 1'b0;
      iAck  <= 1'b0;
      dAck  <= 1'b0;
      case (state_reg)
        ACCESS: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAT) begin
            state_reg <= DONE;
            if (owner_d_reg) begin
              dAck <= 1'b1;
              if (!we_reg) dRdata <= memRdata;
            end else begin
              iAck   <= 1'b1;
              iRdata <= memRdata;
            end
          end
        end
        default: begin
          // IDLE and DONE both arbitrate; an unused encoding falls back to IDLE.
          if (grant_i || grant_d) begin
            state_reg   <= ACCESS;
            cnt_reg     <= 4'd1;
            owner_d_reg <= grant_d;
            we_reg      <= grant_d && dWe;
`ifndef ARB_FIXED_PRIO_EN
            last_d_reg  <= grant_d;
`endif
            memEn       <= 1'b1;
            memWe       <= grant_d && dWe;
            memAddr     <= grant_d ? dAddr : iAddr;
            // Fetches carry no write data, so memWdata keeps the last data-port word.
            if (grant_d) memWdata <= dWdata;
            busy        <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: port drivers push expected read data, a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;
  localparam int AW      = 32;
  localparam int LIMIT   = 200;

  logic          CLK, RESET;
  logic          iReq, iAck, dReq, dWe, dAck, memEn, memWe, busy;
  logic [AW-1:0] iAddr, dAddr, memAddr;
  logic [31:0]   iRdata, dWdata, dRdata, memWdata, memRdata;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdata(iRdata),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dAck(dAck), .dRdata(dRdata),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata),
    .busy(busy)
  );

  typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; int gap;} cmd_t;
  typedef struct {bit is_d; int cyc;} ack_t;

  cmd_t        i_cmd[$], d_cmd[$];
  logic [31:0] i_exp[$], d_exp[$];
  ack_t        ack_log[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem     [0:255];
  logic [31:0] last_d_read, i_hold, d_hold, mon_e;
  int          n_checks, n_pass, cyc, acc_cyc;
  logic        rst_q;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    rst_q <= RESET;
    cyc   <= cyc + 1;
  end

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'h8C220004;
    return (32'(i) * 32'h9E3779B9) ^ 32'h13579BDF;
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  // Reference: instruction region (words 0..63) is read-only, data region (64..255) follows program order.
  function automatic logic [31:0] model_issue(bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata);
    if (!is_d) return ref_mem[addr[9:2]];
    if (we) begin
      ref_mem[addr[9:2]] = wdata;
      return last_d_read;
    end
    last_d_read = ref_mem[addr[9:2]];
    return last_d_read;
  endfunction

  // Memory: data is only valid in the MEM_LAT-th cycle after memEn, otherwise it is corrupted.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    memRdata = '0;
    acc_cyc  = 0;
    forever begin
      @(negedge CLK);
      if (rst_q) acc_cyc = 0;
      if (memEn) begin
        acc_cyc = 1;
        if (memWe) mem[memAddr[9:2]] = memWdata;
      end else if (acc_cyc != 0 && acc_cyc < 100) acc_cyc++;
      memRdata = (acc_cyc == MEM_LAT) ? mem[memAddr[9:2]] : ~mem[memAddr[9:2]];
    end
  end

  always @(negedge CLK) begin
    if (rst_q) begin
      i_hold = '0;
      d_hold = '0;
    end
    if (iAck) begin
      check("i_ack_expected", i_exp.size() != 0, 1);
      if (i_exp.size() != 0) begin
        mon_e = i_exp.pop_front();
        check("i_rdata", iRdata, mon_e);
        i_hold = mon_e;
      end
      ack_log.push_back('{1'b0, cyc});
    end else check("i_rdata_hold", iRdata, i_hold);
    if (dAck) begin
      check("d_ack_expected", d_exp.size() != 0, 1);
      if (d_exp.size() != 0) begin
        mon_e = d_exp.pop_front();
        check("d_rdata", dRdata, mon_e);
        d_hold = mon_e;
      end
      ack_log.push_back('{1'b1, cyc});
    end else check("d_rdata_hold", dRdata, d_hold);
    check("ack_exclusive", iAck & dAck, 0);
  end

  function automatic int q_size(bit is_d);
    return is_d ? d_cmd.size() : i_cmd.size();
  endfunction

  task automatic drive_port(input bit is_d);
    cmd_t c;
    int   k;
    forever begin
      if (q_size(is_d) == 0) begin
        while (q_size(is_d) == 0) @(posedge CLK);
        #1;
      end
      c = is_d ? d_cmd[0] : i_cmd[0];
      repeat (c.gap) begin @(posedge CLK); #1; end
      if (is_d) begin
        dWe = c.we; dAddr = c.addr; dWdata = c.wdata;
        d_exp.push_back(model_issue(1'b1, c.we, c.addr, c.wdata));
        dReq = 1'b1;
      end else begin
        iAddr = c.addr;
        i_exp.push_back(model_issue(1'b0, 1'b0, c.addr, '0));
        iReq = 1'b1;
      end
      k = 0;
      do begin @(negedge CLK); k++; end while (!(is_d ? dAck : iAck) && k < LIMIT);
      check(is_d ? "d_ack_wait" : "i_ack_wait", is_d ? dAck : iAck, 1);
      @(posedge CLK); #1;
      if (is_d) begin
        dReq = 1'b0; dWe = 1'b0;
        void'(d_cmd.pop_front());
      end else begin
        iReq = 1'b0;
        void'(i_cmd.pop_front());
      end
    end
  endtask

  task automatic push_cmd(input bit is_d, input bit we, input int gap);
    cmd_t c;
    c.we    = is_d & we;
    c.addr  = is_d ? 32'($urandom_range(64, 255)) << 2 : 32'($urandom_range(0, 63)) << 2;
    c.wdata = $urandom;
    c.gap   = gap;
    if (is_d) d_cmd.push_back(c);
    else i_cmd.push_back(c);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((i_cmd.size() != 0 || d_cmd.size() != 0) && k < 5000) begin
      @(posedge CLK);
      k++;
    end
    #1;
    check("drain", i_cmd.size() + d_cmd.size(), 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    last_d_read = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_iAck"}, iAck, 0);
    check({tag, "_dAck"}, dAck, 0);
    check({tag, "_memEn"}, memEn, 0);
    check({tag, "_memWe"}, memWe, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_memAddr"}, memAddr, 0);
    check({tag, "_memWdata"}, memWdata, 0);
    check({tag, "_iRdata"}, iRdata, 0);
    check({tag, "_dRdata"}, dRdata, 0);
  endtask

  // Cycle-accurate single access from an idle arbiter; the monitor checks the returned data.
  task automatic direct_access(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input string tag);
    if (is_d) begin
      dWe = we; dAddr = addr; dWdata = wdata;
      d_exp.push_back(model_issue(1'b1, we, addr, wdata));
      dReq = 1'b1;
    end else begin
      iAddr = addr;
      i_exp.push_back(model_issue(1'b0, 1'b0, addr, '0));
      iReq = 1'b1;
    end
    for (int c = 1; c <= MEM_LAT + 1; c++) begin
      @(posedge CLK); #1;
      check({tag, "_memEn"}, memEn, c == 1);
      check({tag, "_memWe"}, memWe, (c == 1) && is_d && we);
      check({tag, "_memAddr"}, memAddr, addr);
      if (is_d) check({tag, "_memWdata"}, memWdata, wdata);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_ack"}, is_d ? dAck : iAck, c == MEM_LAT + 1);
    end
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    @(posedge CLK); #1;
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_order(input string tag, input int mark, input int n,
                             input bit first_d, input int gap);
    check({tag, "_acks"}, ack_log.size() - mark, n);
    if (ack_log.size() - mark == n) begin
      for (int j = 0; j < n; j++) begin
        check({tag, "_port"}, ack_log[mark + j].is_d, first_d ^ (j % 2 == 1) ^ (gap == MEM_LAT + 2 && j % 2 == 1));
        if (j > 0) check({tag, "_spacing"}, ack_log[mark + j].cyc - ack_log[mark + j - 1].cyc, gap);
      end
    end
  endtask

  initial begin
    int mark;
    n_checks = 0; n_pass = 0; cyc = 0;
    RESET = 1'b1; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    iAddr = '0; dAddr = '0; dWdata = '0; last_d_read = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    fork
      drive_port(1'b0);
      drive_port(1'b1);
    join_none

    do_reset();
    check_all_zero("reset");

    direct_access(1'b0, 1'b0, 32'h40, '0, "i_read");
    direct_access(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, "d_write");
    direct_access(1'b1, 1'b0, 32'h100, '0, "d_readback");

    // Tie straight after reset: data first, fetch back-to-back.
    do_reset();
    mark = ack_log.size();
    push_cmd(1'b0, 1'b0, 0);
    push_cmd(1'b1, 1'b0, 0);
    wait_drain();
    check_order("tie_reset", mark, 2, 1'b1, MEM_LAT + 1);

    // Lone data access leaves data as last grant, then a second tie.
    push_cmd(1'b1, 1'b0, 0);
    wait_drain();
    mark = ack_log.size();
    push_cmd(1'b0, 1'b0, 0);
    push_cmd(1'b1, 1'b0, 0);
    wait_drain();
`ifdef ARB_FIXED_PRIO_EN
    check_order("tie_again", mark, 2, 1'b1, MEM_LAT + 1);
`else
    check_order("tie_again", mark, 2, 1'b0, MEM_LAT + 1);
`endif

    // Same port twice must pass through IDLE.
    mark = ack_log.size();
    push_cmd(1'b1, 1'b1, 0);
    push_cmd(1'b1, 1'b0, 0);
    wait_drain();
    check_order("same_port", mark, 2, 1'b1, MEM_LAT + 2);

    // Both held for four accesses: strict alternation without idle gaps.
    do_reset();
    mark = ack_log.size();
    for (int j = 0; j < 2; j++) begin
      push_cmd(1'b0, 1'b0, 0);
      push_cmd(1'b1, 1'b0, 0);
    end
    wait_drain();
    check_order("continuous", mark, 4, 1'b1, MEM_LAT + 1);

    // Reset during cycle 1 of a fetch drops it without an ack.
    iAddr = 32'h40; iReq = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_memEn", memEn, 1);
    RESET = 1'b1; last_d_read = '0;
    @(posedge CLK); #1;
    RESET = 1'b0; iReq = 1'b0;
    check_all_zero("rst_mid");
    mark = ack_log.size();
    repeat (MEM_LAT + 2) @(posedge CLK);
    #1;
    check("rst_mid_no_ack", ack_log.size() - mark, 0);
    push_cmd(1'b1, 1'b0, 0);
    wait_drain();
    check("rst_mid_d_served", ack_log.size() - mark, 1);

    // Randomised traffic on both ports.
    for (int j = 0; j < 30; j++) begin
      push_cmd(1'b0, 1'b0, int'($urandom_range(0, 3)));
      push_cmd(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    wait_drain();
    repeat (2) @(posedge CLK);
    #1;
    check("i_exp_empty", i_exp.size(), 0);
    check("d_exp_empty", d_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
